// File: rtl/irq_pkg.sv
// Shared types and constants for the memory-mapped interrupt controller.
// Gateway states, register offsets within the window, and the "no source" id.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    ACTIVE = 2'd2
  } gw_state_e;

  // Byte offsets of the word registers inside the 0x14-byte window.
  localparam logic [4:0] OFF_PENDING  = 5'h00;
  localparam logic [4:0] OFF_ENABLE   = 5'h04;
  localparam logic [4:0] OFF_TRIGGER  = 5'h08;
  localparam logic [4:0] OFF_CLAIM    = 5'h0C;
  localparam logic [4:0] OFF_COMPLETE = 5'h10;

  localparam logic [31:0] WINDOW_BYTES = 32'h14;
  localparam logic [4:0]  ID_NONE      = 5'd0;

endpackage

// File: rtl/irq_gateway.sv
// Per-source gateway: latches one interrupt line into IDLE/PEND/ACTIVE and
// remembers an edge that arrives while the source is being serviced.
module irq_gateway
  import irq_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      src,
  input  logic      edgeMode,
  input  logic      claim,
  input  logic      complete,
  output logic      pend,
  output gw_state_e state
);

  logic prev;
  logic rearm;
  logic trig;

  // Edge mode fires on a 0->1 transition of the line, level mode on high.
  assign trig = edgeMode ? (src & ~prev) : src;
  assign pend = (state == PEND);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      prev  <= 1'b0;
      rearm <= 1'b0;
    end else begin
      prev <= src;
      case (state)
        IDLE: begin
          if (trig) state <= IDLE == IDLE ? PEND : PEND;
        end
        PEND: begin
          // A claim beats a coincident trigger; an edge in that cycle is kept.
          if (claim) begin
            state <= ACTIVE;
            if (edgeMode && trig) rearm <= 1'b1;
          end
        end
        ACTIVE: begin
          if (complete) begin
            state <= (rearm || (edgeMode && trig)) ? PEND : IDLE;
            rearm <= 1'b0;
          end else if (edgeMode && trig) begin
            rearm <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          rearm <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: per-source gateways, ENABLE/TRIGGER
// registers, lowest-index claim encoder and the registered external request.
module irq_controller
  import irq_pkg::*;
#(
  parameter int          NUM_SRC   = 8,
  parameter logic [31:0] BASE_ADDR = 32'h8000_3000
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic [31:0]        A,
  input  logic               WE,
  input  logic [31:0]        WD,
  output logic [31:0]        RD,
  output logic               sel,
  input  logic [NUM_SRC-1:0] irqSrc,
  output logic               externalIRQ
);

  // Bus protocol: no handshake and no backpressure. A write takes effect on
  // the rising edge where sel & WE are high; reads are combinational from A.
  logic [31:0]        off;
  logic [4:0]         word_off;
  logic               wr;
  logic               wr_enable;
  logic               wr_trigger;
  logic               wr_claim;
  logic               wr_complete;

  logic [NUM_SRC-1:0] enable;
  logic [NUM_SRC-1:0] trigger;
  logic [NUM_SRC-1:0] pend_vec;
  logic [NUM_SRC-1:0] cand;
  logic [NUM_SRC-1:0] claim_vec;
  logic [NUM_SRC-1:0] complete_vec;
  logic [4:0]         claim_id;

  logic [NUM_SRC-1:0][1:0] gw_state_bits;
  logic                    unused_bits;

  assign off      = A - BASE_ADDR;
  assign sel      = (A >= BASE_ADDR) && (off < WINDOW_BYTES);
  assign word_off = {off[4:2], 2'b00};

  assign wr          = sel & WE;
  assign wr_enable   = wr && (word_off == OFF_ENABLE);
  assign wr_trigger  = wr && (word_off == OFF_TRIGGER);
  assign wr_claim    = wr && (word_off == OFF_CLAIM);
  assign wr_complete = wr && (word_off == OFF_COMPLETE);

  // Id 0 and ids beyond NUM_SRC never match a source, so they are dropped here.
  always_comb begin
    claim_vec    = '0;
    complete_vec = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      claim_vec[i]    = wr_claim    && (WD[4:0] == 5'(i + 1));
      complete_vec[i] = wr_complete && (WD[4:0] == 5'(i + 1));
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : gen_gw
    irq_gateway u_gw (
      .clk      (CLK),
      .reset    (reset),
      .src      (irqSrc[g]),
      .edgeMode (trigger[g]),
      .claim    (claim_vec[g]),
      .complete (complete_vec[g]),
      .pend     (pend_vec[g]),
      .state    (gw_state_bits[g])
    );
  end

  assign cand = pend_vec & enable;

  always_comb begin
    claim_id = ID_NONE;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand[i]) claim_id = 5'(i + 1);
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      enable      <= '0;
      trigger     <= '0;
      externalIRQ <= 1'b0;
    end else begin
      if (wr_enable)  enable  <= WD[NUM_SRC-1:0];
      if (wr_trigger) trigger <= WD[NUM_SRC-1:0];
      externalIRQ <= |cand;
    end
  end

  always_comb begin
    RD = 32'h0;
    if (sel) begin
      case (word_off)
        OFF_PENDING: RD = {{(32 - NUM_SRC){1'b0}}, pend_vec};
        OFF_ENABLE:  RD = {{(32 - NUM_SRC){1'b0}}, enable};
        OFF_TRIGGER: RD = {{(32 - NUM_SRC){1'b0}}, trigger};
        OFF_CLAIM:   RD = {27'h0, claim_id};
        default:     RD = 32'h0;
      endcase
    end
  end

  // Upper write-data bits and the gateway state taps have no consumer here.
  assign unused_bits = ^{WD, gw_state_bits};

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed walk through the main scenarios with
// literal expectations, then randomized traffic against a behavioural model.
module tb_irq_controller;

  localparam int          NS   = 8;
  localparam logic [31:0] BASE = 32'h8000_3000;

  logic          CLK = 1'b0;
  logic          reset;
  logic [31:0]   A;
  logic          WE;
  logic [31:0]   WD;
  logic [31:0]   RD;
  logic          sel;
  logic [NS-1:0] irqSrc;
  logic          externalIRQ;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  // Model state: 0 idle, 1 pending, 2 being serviced.
  int      m_st    [NS];
  bit      m_prev  [NS];
  bit      m_rearm [NS];
  bit [NS-1:0] m_en;
  bit [NS-1:0] m_trig;
  bit          m_ext;

  irq_controller #(.NUM_SRC(NS), .BASE_ADDR(BASE)) dut (
    .CLK         (CLK),
    .reset       (reset),
    .A           (A),
    .WE          (WE),
    .WD          (WD),
    .RD          (RD),
    .sel         (sel),
    .irqSrc      (irqSrc),
    .externalIRQ (externalIRQ)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit m_sel(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'h14);
  endfunction

  function automatic bit [NS-1:0] m_pending();
    bit [NS-1:0] p = '0;
    for (int i = 0; i < NS; i++) p[i] = (m_st[i] == 1);
    return p;
  endfunction

  function automatic logic [31:0] m_claim_id();
    for (int i = 0; i < NS; i++)
      if (m_st[i] == 1 && m_en[i]) return 32'(i + 1);
    return 32'd0;
  endfunction

  function automatic logic [31:0] m_rd(input logic [31:0] a);
    if (!m_sel(a)) return 32'h0;
    case ((a - BASE) >> 2)
      0: return 32'(m_pending());
      1: return 32'(m_en);
      2: return 32'(m_trig);
      3: return m_claim_id();
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge CLK) begin
    bit          wr, t, is_claim, is_comp;
    logic [31:0] widx;
    int          id;
    bit          nxt_ext;
    if (reset) begin
      for (int i = 0; i < NS; i++) begin
        m_st[i] = 0; m_prev[i] = 0; m_rearm[i] = 0;
      end
      m_en = '0; m_trig = '0; m_ext = 0;
    end else begin
      nxt_ext = |(m_pending() & m_en);
      wr      = m_sel(A) && WE;
      widx    = (A - BASE) >> 2;
      id      = int'(WD[4:0]);
      for (int i = 0; i < NS; i++) begin
        t        = m_trig[i] ? (irqSrc[i] && !m_prev[i]) : irqSrc[i];
        is_claim = wr && widx == 3 && id == i + 1;
        is_comp  = wr && widx == 4 && id == i + 1;
        if (m_st[i] == 0) begin
          if (t) m_st[i] = 1;
        end else if (m_st[i] == 1) begin
          if (is_claim) begin
            m_st[i] = 2;
            if (m_trig[i] && t) m_rearm[i] = 1;
          end
        end else begin
          if (is_comp) begin
            m_st[i]    = (m_rearm[i] || (m_trig[i] && t)) ? 1 : 0;
            m_rearm[i] = 0;
          end else if (m_trig[i] && t) begin
            m_rearm[i] = 1;
          end
        end
        m_prev[i] = irqSrc[i];
      end
      if (wr && widx == 1) m_en   = WD[NS-1:0];
      if (wr && widx == 2) m_trig = WD[NS-1:0];
      m_ext = nxt_ext;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge CLK) begin
    #1;
    if (chk_en && !reset) begin
      check("model_rd",  RD,                 m_rd(A));
      check("model_sel", {31'h0, sel},       {31'h0, m_sel(A)});
      check("model_ext", {31'h0, externalIRQ}, {31'h0, m_ext});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    @(negedge CLK);
    A = 32'h0; WE = 1'b0; WD = 32'h0;
  endtask

  task automatic wr(input logic [4:0] offs, input logic [31:0] data);
    @(negedge CLK);
    A = BASE + 32'(offs); WE = 1'b1; WD = data;
  endtask

  task automatic rd_chk(input logic [4:0] offs, input logic [31:0] exp, input string name);
    @(negedge CLK);
    A = BASE + 32'(offs); WE = 1'b0; WD = 32'h0;
    #2;
    check(name, RD, exp);
  endtask

  task automatic ext_chk(input bit exp, input string name);
    check(name, {31'h0, externalIRQ}, {31'h0, exp});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; A = 32'h0; WE = 1'b0; WD = 32'h0; irqSrc = '0;
    repeat (3) @(negedge CLK);
    reset  = 1'b0;
    chk_en = 1'b1;

    // Reset values
    rd_chk(5'h00, 32'h0, "rst_pending");
    rd_chk(5'h04, 32'h0, "rst_enable");
    rd_chk(5'h08, 32'h0, "rst_trigger");
    rd_chk(5'h0C, 32'h0, "rst_claim");
    ext_chk(1'b0, "rst_ext");

    // Level source 2
    wr(5'h04, 32'h4);
    idle(); irqSrc = 8'h04;
    rd_chk(5'h00, 32'h4, "lvl_pending");
    ext_chk(1'b0, "lvl_ext_lat1");
    rd_chk(5'h0C, 32'd3, "lvl_claim_rd");
    ext_chk(1'b1, "lvl_ext_lat2");
    wr(5'h0C, 32'd3);
    rd_chk(5'h00, 32'h0, "lvl_claimed_pend");
    ext_chk(1'b1, "lvl_ext_hold");
    rd_chk(5'h0C, 32'h0, "lvl_claimed_rd");
    ext_chk(1'b0, "lvl_ext_fall");
    wr(5'h10, 32'd3);
    rd_chk(5'h00, 32'h0, "lvl_cmpl_idle");
    rd_chk(5'h00, 32'h4, "lvl_repend");
    wr(5'h0C, 32'd3); irqSrc = 8'h00;
    wr(5'h10, 32'd3);
    rd_chk(5'h00, 32'h0, "lvl_clean");

    // Priority between sources 1 and 5
    wr(5'h04, 32'h22); irqSrc = 8'h22;
    idle(); irqSrc = 8'h00;
    rd_chk(5'h0C, 32'd2, "prio_first");
    wr(5'h0C, 32'd2);
    rd_chk(5'h0C, 32'd6, "prio_second");
    wr(5'h04, 32'h2);
    rd_chk(5'h0C, 32'd0, "prio_masked");
    rd_chk(5'h00, 32'h20, "prio_masked_pend");
    wr(5'h0C, 32'd6);
    wr(5'h10, 32'd6);
    wr(5'h10, 32'd2);
    rd_chk(5'h00, 32'h0, "prio_clean");

    // Edge source 0 with rearm
    wr(5'h08, 32'h1);
    wr(5'h04, 32'h1); irqSrc = 8'h01;
    idle(); irqSrc = 8'h00;
    rd_chk(5'h00, 32'h1, "edge_pend");
    wr(5'h0C, 32'd1);
    rd_chk(5'h00, 32'h0, "edge_active");
    idle(); irqSrc = 8'h01;
    idle(); irqSrc = 8'h00;
    wr(5'h10, 32'd1);
    rd_chk(5'h00, 32'h1, "edge_rearm");
    wr(5'h10, 32'd1);
    rd_chk(5'h00, 32'h1, "edge_dbl_cmpl");
    wr(5'h0C, 32'd1);
    wr(5'h10, 32'd1);
    rd_chk(5'h00, 32'h0, "edge_clean");
    wr(5'h08, 32'h0);

    // Invalid operations and decode edges
    wr(5'h04, 32'hFF); irqSrc = 8'h10;
    idle(); irqSrc = 8'h00;
    rd_chk(5'h00, 32'h10, "inv_pend");
    wr(5'h0C, 32'd0);
    wr(5'h0C, 32'd9);
    rd_chk(5'h00, 32'h10, "inv_claim");
    wr(5'h10, 32'd4);
    wr(5'h00, 32'hFF);
    rd_chk(5'h00, 32'h10, "inv_ro_write");
    rd_chk(5'h0C, 32'd5, "inv_claim_rd");
    rd_chk(5'h10, 32'h0, "complete_rd");
    @(negedge CLK);
    WE = 1'b0; A = BASE + 32'h14; #1;
    check("sel_above", {31'h0, sel}, 32'h0);
    A = BASE + 32'h10; #1;
    check("sel_last", {31'h0, sel}, 32'h1);
    A = BASE - 32'h4; #1;
    check("sel_below", {31'h0, sel}, 32'h0);
    wr(5'h0C, 32'd5);
    wr(5'h10, 32'd5);

    // Reset in the middle of service
    idle(); irqSrc = 8'h08;
    wr(5'h0C, 32'd4);
    rd_chk(5'h00, 32'h0, "rst_mid_active");
    idle(); reset = 1'b1;
    idle();
    idle(); reset = 1'b0;
    rd_chk(5'h00, 32'h8, "rst_repend");
    ext_chk(1'b0, "rst_ext_a");
    rd_chk(5'h04, 32'h0, "rst_enable_clr");
    ext_chk(1'b0, "rst_ext_b");
    irqSrc = 8'h00;

    // Randomized traffic, checked every cycle by the compare process
    for (int n = 0; n < 4000; n++) begin
      @(negedge CLK);
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 9) == 0) A = $urandom;
      else A = BASE + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3));
      WE = ($urandom_range(0, 2) == 0);
      WD = $urandom;
      if ($urandom_range(0, 1) == 1) WD[4:0] = 5'($urandom_range(0, 10));
      irqSrc = irqSrc ^ NS'($urandom & $urandom & $urandom);
    end
    @(negedge CLK);
    reset = 1'b0; WE = 1'b0;
    repeat (2) @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
# irq_controller

Memory-mapped interrupt controller for the lltriscv SoC. It collects interrupt lines from peripherals such as the UART and GPIO, and latches each one through a per-source gateway. It drives one external-interrupt request into the datapath trap logic. Software configures it and sequences claim/complete over the data-memory bus, in the same way as the other memory-mapped peripherals.

## Interface
Parameters:
- NUM_SRC, 8, number of interrupt sources; legal range 1..31.
- BASE_ADDR, 32'h8000_3000, word-aligned base of the 0x14-byte register window.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- A  in  32  data-bus address.
- WE  in  1  data-bus write enable.
- WD  in  32  data-bus write data.
- RD  out  32  read data; combinational from A and the current state.
- sel  out  1  high when A falls in [BASE_ADDR, BASE_ADDR+0x14); combinational.
- irqSrc  in  NUM_SRC  interrupt lines from peripherals; synchronous to CLK; source i has id i+1.
- externalIRQ  out  1  registered request to the datapath.

## Operation
Register map (offset, word access only; A[1:0] ignored):
- 0x00 PENDING, RO: bit i = source i is in state PEND.
- 0x04 ENABLE, RW: bit i unmasks source i. Bits ≥ NUM_SRC read 0.
- 0x08 TRIGGER, RW: bit i = 1 selects edge mode (rising edge); 0 selects level mode (high level).
- 0x0C CLAIM:
  - Read returns the id of the lowest-index source that is PEND and enabled, or 0 if there is none. The read has no side effect.
  - Write of WD[4:0]=id moves that source PEND→ACTIVE. The write is ignored if id is 0, out of range, or the source is not PEND.
- 0x10 COMPLETE:
  - Write of WD[4:0]=id moves that source ACTIVE→IDLE, or to PEND if a rearm is recorded. The write is ignored otherwise.
  - Reads return 0.

Per-source gateway states are IDLE, PEND and ACTIVE:
- IDLE→PEND on trigger:
  - level mode: irqSrc[i]=1;
  - edge mode: irqSrc[i]=1 with prev[i]=0, where prev is irqSrc registered every cycle.
- PEND→ACTIVE on a claim write.
- ACTIVE→IDLE on a complete write.
- A trigger that occurs while PEND is absorbed; it does not count.
- An edge-mode trigger while ACTIVE sets rearm[i]. On complete, the source goes to PEND and rearm is cleared.
- Level mode has no rearm. If the line is still high after complete, IDLE→PEND on the next cycle.
- ENABLE does not block capture. A masked source still reaches PEND and shows in PENDING, but is excluded from CLAIM and externalIRQ.

Other rules:
- externalIRQ_next = |(PEND mask & ENABLE).
- Writes are performed only when sel & WE. Writes to RO or unmapped offsets are ignored.
- Changing TRIGGER does not alter the current state. It affects future triggers only.

## Timing
- Reset values: all gateways IDLE; ENABLE=0, TRIGGER=0, prev=0, rearm=0; externalIRQ=0. RD and sel follow A combinationally from the cycle after reset.
- Source latency: trigger sampled at edge n gives PEND after edge n. externalIRQ rises after edge n+1, which is 2 cycles from the line rising.
- A register write at edge n is visible to RD in cycle n+1.
- A claim write at edge n drops the source from the candidate set in cycle n+1. externalIRQ falls after edge n+1 if no other candidate remains.
- Same-cycle trigger and claim on a PEND source: the claim wins (state becomes ACTIVE). An edge trigger in that cycle sets rearm.
- Same-cycle trigger and complete on an ACTIVE source:
  - edge mode: the source goes to PEND;
  - level mode: the source goes to IDLE, then to PEND on the next edge if the line is still high.
- Only one bus write can occur per cycle, so claim and complete never collide.
- Reset asserted mid-service returns everything to reset values on that edge. Triggers present on the reset edge are lost; a level still high re-pends one cycle after reset deasserts.

## Structure
- irq_pkg holds:
  - the gateway state enum (IDLE, PEND, ACTIVE);
  - register offset constants (OFF_PENDING, OFF_ENABLE, OFF_TRIGGER, OFF_CLAIM, OFF_COMPLETE);
  - ID_NONE = 0.
- Sub-module irq_gateway: one per source, generated NUM_SRC times.
  - Inputs: src, edgeMode, claim, complete.
  - Outputs: pend.
  - Holds the source's state, prev and rearm.
- The top level contains the address decode, the ENABLE/TRIGGER registers, the lowest-index priority encoder and the externalIRQ register.

## Test plan
- Reset, then read every register → PENDING=0, ENABLE=0, TRIGGER=0, CLAIM=0, externalIRQ=0.
- Level source 2 enabled (ENABLE=0x4), irqSrc[2] held high → PENDING=0x4 and externalIRQ=1 two cycles after the rise; CLAIM reads 3. Write CLAIM=3 → PENDING=0, externalIRQ=0 one cycle later. Write COMPLETE=3 with the line still high → PEND again the next cycle.
- Sources 1 and 5 pending, both enabled → CLAIM reads 2. Claim 2 → CLAIM reads 6. Mask source 5 (ENABLE=0x2) → CLAIM=0 and PENDING bit 5 remains set.
- Edge source 0 (TRIGGER=1): pulse, claim id 1, pulse again while ACTIVE, complete → source returns to PEND immediately; a second complete without a new claim is ignored.
- Invalid ops: claim id 0, claim id 9 with NUM_SRC=8, and complete on an IDLE source → no state change. Writes to 0x00 are ignored. Address BASE+0x14 → sel=0.
- Assert reset while source 3 is ACTIVE and ENABLE=0xFF → all state cleared; with irqSrc[3] still high (level mode), PEND appears one cycle after reset drops, but externalIRQ stays 0 because ENABLE=0.
